// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the buffer-RAM stream reader: FSM encodings and width helpers.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int FIFO_DEPTH = 2;

    // Bits needed to hold an occupancy count from 0 up to and including depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// AXI-Stream style valid/ready channel carrying one data word plus an end-of-block marker.
interface ram_stream_reader_if #(
    parameter int DWIDTH = 16
) ();

    logic [DWIDTH-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/ram_stream_reader_fifo2.sv
// Two-entry registered FIFO holding read data and its tlast tag; head entry drives the stream.
module ram_stream_reader_fifo2
    import ram_stream_reader_pkg::*;
#(
    parameter int DWIDTH = 16,
    localparam int CW    = count_width(FIFO_DEPTH)
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              i_push,
    input  logic [DWIDTH-1:0] i_push_data,
    input  logic              i_push_last,
    input  logic              i_pop,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_last,
    output logic              o_valid,
    output logic [CW-1:0]     o_count
);

    logic [DWIDTH-1:0] r_data [FIFO_DEPTH];
    logic [1:0]        r_last;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [CW-1:0]     r_count;

    always_ff @(posedge aclk) begin
        if (areset) begin
            // NOTE: storage is reset here only because tdata must read zero after reset;
            // larger buffers should leave their array unreset and rely on the valid flag.
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_last    <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= '0;
        end else begin
            if (i_push) begin
                r_data[r_wr_ptr] <= i_push_data;
                r_last[r_wr_ptr] <= i_push_last;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_data[r_rd_ptr];
    assign o_last  = r_last[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a block of buffer-RAM words forward or in reverse and turns the latency-1 read
// data into a valid/ready stream with full backpressure.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                start,
    input  logic [AW-1:0]       base_addr,
    input  logic [AW:0]         length,
    input  logic                reverse,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       rd_addr,
    input  logic [DWIDTH-1:0]   rd_data,
    ram_stream_reader_if.master m_axis
);

    localparam logic [AW:0] MAX_LEN = (AW + 1)'(DEPTH);
    localparam int          CW      = count_width(FIFO_DEPTH);

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_reverse;
    logic              r_inflight;
    logic              r_inflight_last;
    logic [AW-1:0]     r_next_addr;
    logic [AW-1:0]     r_rd_addr;
    logic [AW:0]       r_remaining;

    logic [AW:0]       w_len;
    logic [AW-1:0]     w_rev_start;
    logic [CW-1:0]     w_fifo_count;
    logic [CW-1:0]     w_occ;
    logic              w_pop;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_fifo_valid;
    logic              w_fifo_last;
    logic [DWIDTH-1:0] w_fifo_data;

    assign w_len       = (length > MAX_LEN) ? MAX_LEN : length;
    assign w_rev_start = base_addr + w_len[AW-1:0] - AW'(1);

    // Occupancy counts the read whose data lands this cycle, so a full slot is reusable
    // only when the head beat leaves in the same cycle.
    assign w_pop        = w_fifo_valid & m_axis.tready;
    assign w_occ        = w_fifo_count + CW'(r_inflight);
    assign w_issue      = (r_state == ST_READ) && (r_remaining != '0) &&
                          ((w_occ < CW'(FIFO_DEPTH)) || ((w_occ == CW'(FIFO_DEPTH)) && w_pop));
    assign w_last_issue = w_issue && (r_remaining == (AW + 1)'(1));

    // The address is presented in the cycle the read is issued so the RAM latency is hidden.
    assign rd_addr = w_issue ? r_next_addr : r_rd_addr;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state         <= ST_IDLE;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_reverse       <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_next_addr     <= '0;
            r_rd_addr       <= '0;
            r_remaining     <= '0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_last_issue;
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        if (w_len == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= ST_READ;
                            r_busy      <= 1'b1;
                            r_reverse   <= reverse;
                            r_remaining <= w_len;
                            r_next_addr <= reverse ? w_rev_start : base_addr;
                        end
                    end
                end
                ST_READ: begin
                    if (w_issue) begin
                        r_rd_addr   <= r_next_addr;
                        r_next_addr <= r_reverse ? (r_next_addr - AW'(1)) : (r_next_addr + AW'(1));
                        r_remaining <= r_remaining - (AW + 1)'(1);
                        if (w_last_issue) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && w_fifo_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    ram_stream_reader_fifo2 #(
        .DWIDTH (DWIDTH)
    ) u_fifo (
        .aclk        (aclk),
        .areset      (areset),
        .i_push      (r_inflight),
        .i_push_data (rd_data),
        .i_push_last (r_inflight_last),
        .i_pop       (w_pop),
        .o_data      (w_fifo_data),
        .o_last      (w_fifo_last),
        .o_valid     (w_fifo_valid),
        .o_count     (w_fifo_count)
    );

    assign busy          = r_busy;
    assign done          = r_done;
    assign m_axis.tdata  = w_fifo_data;
    assign m_axis.tvalid = w_fifo_valid;
    assign m_axis.tlast  = w_fifo_last;

endmodule
